// File: rtl/regfile_port_arb_if.sv
// Requester-side bundle for regfile_port_arb: per-requester request handshake
// plus the per-requester response pulse and the shared response data word.
interface regfile_port_arb_if #(
    parameter int NREQ  = 2,
    parameter int NADDR = 4
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*NADDR-1:0] req_addr;
    logic [NREQ*32-1:0]    req_wdata;
    logic [NREQ*4-1:0]     req_we;
    logic [NREQ-1:0]       rsp_valid;
    logic [31:0]           rsp_data;

    modport master (
        output req_valid, req_addr, req_wdata, req_we,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_addr, req_wdata, req_we,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/regfile_port_arb.sv
// Round-robin arbiter that time-shares one mem_regfile port between NREQ
// requesters, one single-word transaction at a time.
//
//   state | meaning
//   IDLE  | no transaction in flight; arbitrate and accept
//   ISSUE | drive mem_en for one cycle with the registered request
//   WAIT  | count down RD_LAT cycles, capture read data on the last one
//   RESP  | pulse rsp_valid to the owner; may accept the next request
module regfile_port_arb #(
    parameter int NREQ   = 2,
    parameter int NADDR  = 4,
    parameter int RD_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    regfile_port_arb_if.slave    req_if,
    output logic                 mem_en_o,
    output logic [3:0]           mem_we_o,
    output logic [NADDR-1:0]     mem_addr_o,
    output logic [31:0]          mem_wr_data_o,
    input  logic [31:0]          mem_rd_data_i,
    output logic                 busy_o
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(RD_LAT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t           state_q, state_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [PW-1:0]    owner_q, owner_d;
    logic [NADDR-1:0] addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [31:0]      rdata_q, rdata_d;
    logic [3:0]       we_q, we_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [NREQ-1:0]  grant;
    logic [NREQ-1:0]  rsp_vld;
    logic             found;
    int               winner;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            we_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            we_q    <= we_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        we_d    = we_q;
        cnt_d   = cnt_q;
        grant   = '0;
        rsp_vld = '0;
        found   = 1'b0;
        winner  = 0;

        // Rotating priority: first scan from the pointer up, then wrap to the low indices.
        if (state_q == IDLE || state_q == RESP) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!found && req_if.req_valid[i] && i >= int'(ptr_q)) begin
                    found  = 1'b1;
                    winner = i;
                end
            end
            for (int i = 0; i < NREQ; i++) begin
                if (!found && req_if.req_valid[i]) begin
                    found  = 1'b1;
                    winner = i;
                end
            end
        end

        for (int i = 0; i < NREQ; i++) begin
            if (found && winner == i) begin
                grant[i] = 1'b1;
                addr_d   = req_if.req_addr[i*NADDR +: NADDR];
                wdata_d  = req_if.req_wdata[i*32 +: 32];
                we_d     = req_if.req_we[i*4 +: 4];
            end
            if (state_q == RESP && int'(owner_q) == i) begin
                rsp_vld[i] = 1'b1;
            end
        end

        if (found) begin
            owner_d = PW'(winner);
            ptr_d   = (winner == NREQ - 1) ? '0 : PW'(winner + 1);
        end

        case (state_q)
            IDLE: begin
                if (found) state_d = ISSUE;
            end
            ISSUE: begin
                cnt_d   = CW'(RD_LAT);
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q == CW'(1)) begin
                    rdata_d = (we_q != 4'd0) ? 32'd0 : mem_rd_data_i;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            RESP: begin
                state_d = found ? ISSUE : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign req_if.req_ready = grant;
    assign req_if.rsp_valid = rsp_vld;
    assign req_if.rsp_data  = rdata_q;
    assign mem_en_o         = (state_q == ISSUE);
    assign mem_we_o         = (state_q == ISSUE) ? we_q : 4'd0;
    assign mem_addr_o       = addr_q;
    assign mem_wr_data_o    = wdata_q;
    assign busy_o           = (state_q != IDLE);
endmodule

// File: tb/tb_regfile_port_arb.sv
// Directed bench for regfile_port_arb: one RD_LAT=1 instance and one RD_LAT=2
// instance, each in front of a small behavioural regfile.
module tb_regfile_port_arb;
    logic clk = 1'b0;
    logic rst_n;
    logic mem_load;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    regfile_port_arb_if #(.NREQ(2), .NADDR(4)) a_if ();
    regfile_port_arb_if #(.NREQ(2), .NADDR(4)) b_if ();

    logic        a_en, b_en, a_busy, b_busy;
    logic [3:0]  a_we, b_we, a_addr, b_addr;
    logic [31:0] a_wdata, b_wdata, a_rd1, b_rd1, b_rd2;
    logic [31:0] mem_a [16];
    logic [31:0] mem_b [16];

    regfile_port_arb #(.NREQ(2), .NADDR(4), .RD_LAT(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .req_if(a_if.slave),
        .mem_en_o(a_en), .mem_we_o(a_we), .mem_addr_o(a_addr),
        .mem_wr_data_o(a_wdata), .mem_rd_data_i(a_rd1), .busy_o(a_busy)
    );

    regfile_port_arb #(.NREQ(2), .NADDR(4), .RD_LAT(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .req_if(b_if.slave),
        .mem_en_o(b_en), .mem_we_o(b_we), .mem_addr_o(b_addr),
        .mem_wr_data_o(b_wdata), .mem_rd_data_i(b_rd2), .busy_o(b_busy)
    );

    // Behavioural regfiles: word i initialised to i*0x1111_1111, word 3 of A is 0x3333_3030.
    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 16; i++) begin
                mem_a[i] <= 32'h1111_1111 * 32'(i);
                mem_b[i] <= 32'h1111_1111 * 32'(i);
            end
            mem_a[3] <= 32'h3333_3030;
        end else begin
            if (a_en) begin
                for (int k = 0; k < 4; k++)
                    if (a_we[k]) mem_a[a_addr][8*k +: 8] <= a_wdata[8*k +: 8];
                a_rd1 <= mem_a[a_addr];
            end
            if (b_en) begin
                for (int k = 0; k < 4; k++)
                    if (b_we[k]) mem_b[b_addr][8*k +: 8] <= b_wdata[8*k +: 8];
                b_rd1 <= mem_b[b_addr];
            end
            b_rd2 <= b_rd1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Single transaction on DUT A with fixed RD_LAT=1 timing: accept T, mem_en T+1, rsp T+3.
    task automatic txn(input string tag, input logic r, input logic [3:0] addr,
                       input logic [31:0] wd, input logic [3:0] we, input logic [31:0] exp);
        logic [1:0] oh;
        oh = r ? 2'b10 : 2'b01;
        if (r) begin
            a_if.req_addr[7:4]   = addr;
            a_if.req_wdata[63:32] = wd;
            a_if.req_we[7:4]     = we;
        end else begin
            a_if.req_addr[3:0]   = addr;
            a_if.req_wdata[31:0] = wd;
            a_if.req_we[3:0]     = we;
        end
        a_if.req_valid = oh;
        #1;
        check({tag, " ready"}, 32'(a_if.req_ready), 32'(oh));
        step();
        a_if.req_valid = 2'b00;
        check({tag, " issue en"}, 32'(a_en), 32'd1);
        check({tag, " issue addr"}, 32'(a_addr), 32'(addr));
        check({tag, " issue we"}, 32'(a_we), 32'(we));
        check({tag, " issue wdata"}, a_wdata, wd);
        check({tag, " ready in issue"}, 32'(a_if.req_ready), 32'd0);
        step();
        check({tag, " wait en"}, {27'd0, a_en, a_we}, 32'd0);
        check({tag, " wait addr hold"}, 32'(a_addr), 32'(addr));
        check({tag, " wait rsp"}, 32'(a_if.rsp_valid), 32'd0);
        step();
        check({tag, " rsp valid"}, 32'(a_if.rsp_valid), 32'(oh));
        check({tag, " rsp data"}, a_if.rsp_data, exp);
        step();
        check({tag, " rsp pulse end"}, 32'(a_if.rsp_valid), 32'd0);
        check({tag, " idle busy"}, 32'(a_busy), 32'd0);
        check({tag, " rsp data hold"}, a_if.rsp_data, exp);
    endtask

    initial begin
        logic [1:0]  exp_rdy, exp_rsp;
        logic [31:0] exp_dat;

        rst_n          = 1'b0;
        mem_load       = 1'b1;
        a_if.req_valid = '0; a_if.req_addr = '0; a_if.req_wdata = '0; a_if.req_we = '0;
        b_if.req_valid = '0; b_if.req_addr = '0; b_if.req_wdata = '0; b_if.req_we = '0;
        step();
        step();
        mem_load = 1'b0;
        check("reset busy", 32'(a_busy), 32'd0);
        check("reset mem_en/we", {27'd0, a_en, a_we}, 32'd0);
        check("reset mem_addr", 32'(a_addr), 32'd0);
        check("reset mem_wr_data", a_wdata, 32'd0);
        check("reset rsp_valid", 32'(a_if.rsp_valid), 32'd0);
        check("reset rsp_data", a_if.rsp_data, 32'd0);
        check("reset ready", 32'(a_if.req_ready), 32'd0);
        check("reset B busy", 32'(b_busy), 32'd0);
        rst_n = 1'b1;
        step();

        // Single read, write-then-read, byte enables.
        txn("t1 read2", 1'b0, 4'd2, 32'h0, 4'h0, 32'h2222_2222);
        txn("t2 write5", 1'b1, 4'd5, 32'hA5A5_0F0F, 4'hF, 32'h0);
        txn("t2 read5", 1'b1, 4'd5, 32'h0, 4'h0, 32'hA5A5_0F0F);
        txn("t3 write3", 1'b1, 4'd3, 32'h1234_5678, 4'b0101, 32'h0);
        txn("t3 read3", 1'b1, 4'd3, 32'h0, 4'h0, 32'h3334_3078);

        // Contention: pointer is 0, grants 0,1,0,1,0,1 at cycles 0,3,..,15.
        a_if.req_addr  = {4'd4, 4'd1};
        a_if.req_we    = '0;
        a_if.req_valid = 2'b11;
        for (int c = 0; c < 20; c++) begin
            if (c == 16) a_if.req_valid = 2'b00;
            #1;
            exp_rdy = (c % 3 == 0 && c < 18) ? 2'(2'b01 << ((c / 3) % 2)) : 2'b00;
            check("t4 grant", 32'(a_if.req_ready), 32'(exp_rdy));
            exp_rsp = (c >= 3 && c % 3 == 0 && c <= 18) ? 2'(2'b01 << (((c / 3) - 1) % 2)) : 2'b00;
            check("t4 rsp owner", 32'(a_if.rsp_valid), 32'(exp_rsp));
            if (exp_rsp != 2'b00) begin
                exp_dat = (exp_rsp == 2'b10) ? 32'h4444_4444 : 32'h1111_1111;
                check("t4 rsp data", a_if.rsp_data, exp_dat);
            end
            step();
        end

        // Reset during WAIT after granting req0 (pointer then 1).
        a_if.req_addr  = {4'd0, 4'd2};
        a_if.req_valid = 2'b01;
        #1;
        check("t5 ready", 32'(a_if.req_ready), 32'd1);
        step();
        a_if.req_valid = 2'b00;
        step();
        check("t5 in wait", 32'(a_busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t5 busy", 32'(a_busy), 32'd0);
        check("t5 mem_en/we", {27'd0, a_en, a_we}, 32'd0);
        check("t5 mem_addr", 32'(a_addr), 32'd0);
        check("t5 rsp_valid", 32'(a_if.rsp_valid), 32'd0);
        check("t5 rsp_data", a_if.rsp_data, 32'd0);
        step();
        check("t5 rsp in reset", 32'(a_if.rsp_valid), 32'd0);
        step();
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("t5 no stale rsp", 32'(a_if.rsp_valid), 32'd0);
            check("t5 idle", 32'(a_busy), 32'd0);
            step();
        end
        a_if.req_addr  = {4'd9, 4'd6};
        a_if.req_valid = 2'b11;
        #1;
        check("t5 first grant", 32'(a_if.req_ready), 32'd1);
        step();
        a_if.req_valid = 2'b00;
        step();
        step();
        check("t5 rsp valid", 32'(a_if.rsp_valid), 32'd1);
        check("t5 rsp data", a_if.rsp_data, 32'h6666_6666);
        step();

        // RD_LAT=2 instance: read addr 7, response at T+4.
        b_if.req_addr  = {4'd0, 4'd7};
        b_if.req_valid = 2'b01;
        #1;
        check("t6 ready", 32'(b_if.req_ready), 32'd1);
        step();
        b_if.req_valid = 2'b00;
        check("t6 mem_en", 32'(b_en), 32'd1);
        step();
        check("t6 T+2 en", 32'(b_en), 32'd0);
        check("t6 T+2 rsp", 32'(b_if.rsp_valid), 32'd0);
        step();
        check("t6 T+3 rsp", 32'(b_if.rsp_valid), 32'd0);
        check("t6 T+3 busy", 32'(b_busy), 32'd1);
        step();
        check("t6 T+4 rsp", 32'(b_if.rsp_valid), 32'd1);
        check("t6 T+4 data", b_if.rsp_data, 32'h7777_7777);
        step();
        check("t6 idle", 32'(b_busy), 32'd0);

        // Back-to-back on RD_LAT=2: pointer is 1, grants 1,0,1 at cycles 0,4,8.
        b_if.req_addr  = {4'd2, 4'd7};
        b_if.req_valid = 2'b11;
        for (int c = 0; c < 14; c++) begin
            if (c == 9) b_if.req_valid = 2'b00;
            #1;
            exp_rdy = (c % 4 == 0 && c < 12) ? (((c / 4) % 2 == 1) ? 2'b01 : 2'b10) : 2'b00;
            check("t6 b2b grant", 32'(b_if.req_ready), 32'(exp_rdy));
            exp_rsp = (c >= 4 && c % 4 == 0 && c <= 12) ? (((c / 4) % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
            check("t6 b2b rsp", 32'(b_if.rsp_valid), 32'(exp_rsp));
            if (exp_rsp != 2'b00) begin
                exp_dat = (exp_rsp == 2'b10) ? 32'h2222_2222 : 32'h7777_7777;
                check("t6 b2b data", b_if.rsp_data, exp_dat);
            end
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
